// File: rtl/bitwise_operand_loader_if.sv
// Operand-loader bus: switch bank, pushbutton, restart and the registered operand pair.
// Ports: sw, load_btn, clr (master -> slave); A, B, valid, load_ack, state (slave -> master).
interface bitwise_operand_loader_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] sw;
    logic             load_btn;
    logic             clr;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             valid;
    logic             load_ack;
    logic [1:0]       state;

    modport master (
        output sw,
        output load_btn,
        output clr,
        input  A,
        input  B,
        input  valid,
        input  load_ack,
        input  state
    );

    modport slave (
        input  sw,
        input  load_btn,
        input  clr,
        output A,
        output B,
        output valid,
        output load_ack,
        output state
    );
endinterface

// File: rtl/bitwise_operand_loader.sv
// Loads operands A then B from a shared switch bank, one per accepted button press.
// Ports: clk, rst (async, active-high), bus (slave modport: sw, load_btn, clr in;
// A, B, valid, load_ack, state out). Define LOADER_DEBOUNCE_EN to insert the debouncer.
module bitwise_operand_loader #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    bitwise_operand_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        READY   = 2'd2,
        ILLEGAL = 2'd3
    } state_e;

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------
    // Button input path
    // ------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic btn_lvl;
    logic btn_lvl_d_q;
    logic press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.load_btn;
            sync2_q <= sync1_q;
        end
    end

`ifdef LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] db_cnt_q;
    logic [CW-1:0] db_cnt_d;
    logic          db_lvl_q;
    logic          db_lvl_d;

    // The counter holds the number of earlier mismatching cycles, so the
    // cycle that completes the run releases the new level combinationally.
    // This keeps the capture edge at k+1+DEBOUNCE_CYCLES.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        btn_lvl  = db_lvl_q;
        if (sync2_q != db_lvl_q) begin
            if (db_cnt_q == CNT_LAST) begin
                btn_lvl  = sync2_q;
                db_lvl_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end
`else
    assign btn_lvl = sync2_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_lvl_d_q <= 1'b0;
        end else begin
            btn_lvl_d_q <= btn_lvl;
        end
    end

    assign press = btn_lvl & ~btn_lvl_d_q;

    // ------------------------------------------------------------
    // Operand FSM
    // ------------------------------------------------------------
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             valid_q;
    logic             valid_d;
    logic             ack_q;
    logic             ack_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        ack_d   = 1'b0;

        // A press coinciding with clr is dropped here; the edge detector
        // has already moved on, so it is never replayed.
        if (bus.clr) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_A: begin
                    if (press) begin
                        a_d     = bus.sw;
                        ack_d   = 1'b1;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (press) begin
                        b_d     = bus.sw;
                        valid_d = 1'b1;
                        ack_d   = 1'b1;
                        state_d = READY;
                    end
                end
                READY: begin
                    // B is kept until the next B load.
                    if (press) begin
                        a_d     = bus.sw;
                        valid_d = 1'b0;
                        ack_d   = 1'b1;
                        state_d = WAIT_B;
                    end
                end
                ILLEGAL: begin
                    state_d = WAIT_A;
                    a_d     = '0;
                    b_d     = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.valid    = valid_q;
    assign bus.load_ack = ack_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_bitwise_operand_loader.sv
// Randomized and directed bench for bitwise_operand_loader against an edge-history model.
// Builds with or without LOADER_DEBOUNCE_EN; expected latency follows the build.
module tb_bitwise_operand_loader;

    localparam int W  = 4;
    localparam int DB = 4;
`ifdef LOADER_DEBOUNCE_EN
    localparam int LAT = 1 + DB;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitwise_operand_loader_if #(.WIDTH(W)) bus ();

    bitwise_operand_loader #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: history of button samples per edge, accepted level,
    // number of operands loaded in the current pair (0, 1 or 2).
    bit         hist[$];
    bit         mlvl;
    int         mcnt;
    logic [W-1:0] mA;
    logic [W-1:0] mB;
    bit         mack;
    int         nack;

    // h(1) is the sample at the current edge, h(2) the previous one, ...
    function automatic bit h(int i);
        if (hist.size() < i) return 1'b0;
        return hist[hist.size() - i];
    endfunction

    task automatic model_reset();
        hist.delete();
        mlvl = 0;
        mcnt = 0;
        mA   = '0;
        mB   = '0;
        mack = 0;
    endtask

    task automatic model_edge();
        bit pr;
        bit v;
        bit same;
        hist.push_back(bus.load_btn);
        if (hist.size() > 32) void'(hist.pop_front());
        pr = 0;
`ifdef LOADER_DEBOUNCE_EN
        // Synchronized level seen in the last DB cycles before this edge.
        v    = h(3);
        same = 1;
        for (int i = 4; i <= 2 + DB; i++) if (h(i) != v) same = 0;
        if (same && v != mlvl) begin
            mlvl = v;
            pr   = v;
        end
`else
        v    = h(3);
        same = !h(4);
        pr   = v && same;
`endif
        if (bus.clr) begin
            mcnt = 0;
            mA   = '0;
            mB   = '0;
            mack = 0;
        end else if (pr) begin
            mack = 1;
            if (mcnt == 1) begin
                mB   = bus.sw;
                mcnt = 2;
            end else begin
                mA   = bus.sw;
                mcnt = 1;
            end
        end else begin
            mack = 0;
        end
    endtask

    task automatic check_all();
        chk("A", 32'(bus.A), 32'(mA));
        chk("B", 32'(bus.B), 32'(mB));
        chk("valid", 32'(bus.valid), 32'(mcnt == 2));
        chk("load_ack", 32'(bus.load_ack), 32'(mack));
        chk("state", 32'(bus.state), 32'(mcnt));
        if (bus.load_ack === 1'b1) nack++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic press_op(input logic [W-1:0] v, input int hold);
        int lat;
        int a0;
        lat = 0;
        a0  = nack;
        bus.sw       = v;
        bus.load_btn = 1'b1;
        for (int i = 1; i <= hold; i++) begin
            step();
            if (bus.load_ack === 1'b1 && lat == 0) lat = i;
        end
        bus.load_btn = 1'b0;
        repeat (LAT + 2) step();
        chk("press_latency", 32'(lat), 32'(LAT + 1));
        chk("acks_per_press", 32'(nack - a0), 32'd1);
    endtask

    initial begin
        int a0;
        bus.sw       = '0;
        bus.load_btn = 1'b0;
        bus.clr      = 1'b0;
        nack         = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Basic pair load
        press_op(4'b1010, LAT + 2);
        press_op(4'b0101, LAT + 2);
        chk("A_or_B", 32'(bus.A | bus.B), 32'hF);
        chk("A_and_B", 32'(bus.A & bus.B), 32'h0);
        chk("state_ready", 32'(bus.state), 32'd2);

        // Held 20 cycles in READY: one reload of A only
        press_op(4'b1111, 20);
        chk("reload_A", 32'(bus.A), 32'hF);
        chk("keep_B", 32'(bus.B), 32'h5);
        chk("state_wait_b", 32'(bus.state), 32'd1);

        // clr coinciding with the capture edge in WAIT_B
        a0           = nack;
        bus.sw       = 4'b0011;
        bus.load_btn = 1'b1;
        repeat (LAT) step();
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        repeat (6) step();
        bus.load_btn = 1'b0;
        repeat (LAT + 2) step();
        chk("clr_no_ack", 32'(nack - a0), 32'd0);
        chk("clr_state", 32'(bus.state), 32'd0);
        chk("clr_A", 32'(bus.A), 32'd0);

`ifdef LOADER_DEBOUNCE_EN
        a0           = nack;
        bus.load_btn = 1'b1;
        repeat (DB - 1) step();
        bus.load_btn = 1'b0;
        repeat (DB + 4) step();
        chk("glitch_ignored", 32'(nack - a0), 32'd0);
        press_op(4'b0110, 10);
`endif

        // Asynchronous reset while READY
        press_op(4'b0001, LAT + 2);
        press_op(4'b0010, LAT + 2);
        chk("pre_rst_valid", 32'(bus.valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_A", 32'(bus.A), 32'd0);
        chk("arst_B", 32'(bus.B), 32'd0);
        chk("arst_valid", 32'(bus.valid), 32'd0);
        chk("arst_state", 32'(bus.state), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        press_op(4'b1001, LAT + 2);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            step();
            if ($urandom_range(0, 3) == 0) bus.load_btn = ~bus.load_btn;
            bus.sw  = W'($urandom);
            bus.clr = ($urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitwise_operand_loader.md
# bitwise_operand_loader

- Upstream stage of `bitwise_operators`: turns one shared WIDTH-bit switch bank plus a pushbutton into the registered operand pair `A`, `B`.
- A three-state FSM captures `A` on the first accepted press and `B` on the second, then asserts `valid`.
- `load_btn` passes through a 2-FF synchronizer, optional debouncer and rising-edge detector, so one physical press loads exactly one operand.

## Interface

Parameters:
- `WIDTH`, default 4: operand width; must match the downstream `bitwise_operators` instance.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed before a button level change is accepted. Must be ≥ 1. Used only when `LOADER_DEBOUNCE_EN` is defined.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sw`  in  WIDTH: operand value from the switches. Sampled unsynchronized on the capture edge; must be stable at that edge.
- `load_btn`  in  1: raw pushbutton, asynchronous to `clk`.
- `clr`  in  1: synchronous restart of the operand sequence, active-high.
- `A`  out  WIDTH: registered operand A, to `bitwise_operators.A`.
- `B`  out  WIDTH: registered operand B, to `bitwise_operators.B`.
- `valid`  out  1: high while both operands of the current pair are loaded.
- `load_ack`  out  1: one-cycle pulse on the edge an operand is captured.
- `state`  out  2: FSM state encoding, for LEDs and debug.

## Operation

- Input path:
  - `load_btn` → sync1 → sync2 → (debounce) → level `btn_lvl`.
  - `press` = `btn_lvl` & ~`btn_lvl_d`, where `btn_lvl_d` is `btn_lvl` delayed one cycle.
- FSM states: `WAIT_A` = 2'd0, `WAIT_B` = 2'd1, `READY` = 2'd2. Encoding 2'd3 is illegal; if reached, the next edge goes to `WAIT_A` with all outputs cleared.
- `WAIT_A` + `press`: `A` ← `sw`, `load_ack` = 1, go to `WAIT_B`.
- `WAIT_B` + `press`: `B` ← `sw`, `valid` ← 1, `load_ack` = 1, go to `READY`.
- `READY` + `press`: `A` ← `sw`, `valid` ← 0, `load_ack` = 1, go to `WAIT_B`. `B` holds its old value until reloaded.
- No `press`: state, `A`, `B` and `valid` hold; `load_ack` = 0.
- `clr` (any state):
  - Next edge: `A` = 0, `B` = 0, `valid` = 0, state = `WAIT_A`, `load_ack` = 0.
  - `clr` wins over a simultaneous `press`, and that press is consumed, not deferred.
  - Synchronizer and debouncer state is not cleared by `clr`.
- Button held continuously: exactly one `press`. A new press requires release (accepted as a low level) followed by a new accepted high level.

## Timing

- Reset values: `A` = 0, `B` = 0, `valid` = 0, `load_ack` = 0, `state` = 2'd0. sync1, sync2, `btn_lvl`, `btn_lvl_d` and the debounce counter are all 0.
- If `load_btn` is held across reset release, it produces one `press` after release.
- Let edge k be the first rising edge at which `load_btn` is sampled high.
- Without debounce, the capture edge is k+2:
  - `A`/`B`, `state`, `valid` and `load_ack` update at edge k+2.
  - `load_ack` is high for the cycle that follows.
- With debounce, the capture edge is k+1+`DEBOUNCE_CYCLES`.
- `valid` and `A`/`B` are registered, so the downstream combinational outputs are valid in the same cycle as `valid`.
- `rst` asserted mid-sequence immediately forces the reset values, independent of `clk`.

## Configuration

- `LOADER_DEBOUNCE_EN` defined:
  - Counter of width `$clog2(DEBOUNCE_CYCLES+1)` increments while sync2 ≠ `btn_lvl` and resets to 0 when they are equal.
  - When it reaches `DEBOUNCE_CYCLES`, `btn_lvl` ← sync2 and the counter resets.
  - Pulses or gaps shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- `LOADER_DEBOUNCE_EN` undefined: `btn_lvl` = sync2 and no counter is instantiated. Every synchronized level change counts.

## Test plan

- Reset, then `sw` = 4'b1010 with press, then `sw` = 4'b0101 with press → `A` = 1010, `B` = 0101, `valid` = 1, `state` = 2; downstream sees `A_or_B` = 1111, `A_and_B` = 0000.
- Press latency, debounce off: `load_btn` rises before edge k → `load_ack` and `A` change at edge k+2. Button held 20 cycles → exactly one `load_ack`.
- Press in `READY` with `sw` = 4'b1111 → `A` = 1111, `B` still 0101, `valid` = 0, `state` = 1.
- `clr` and `press` in the same cycle in `WAIT_B` → `state` = 0, `A` = `B` = 0, no `load_ack`, and no capture on later cycles.
- Debounce on, `DEBOUNCE_CYCLES` = 4:
  - 3-cycle glitch → no `load_ack`.
  - Held 10 cycles → one capture, at edge k+5.
- `rst` pulsed between edges while in `READY` → outputs go to 0 before the next edge; the FSM restarts in `WAIT_A`.
